// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads the program ROM and hands instructions to
// decode over a valid/ready handshake. Execute may redirect the PC.
// Ports:
//   clk, rst (async, active-low), start (restart pulse)
//   rom_line / rom_data        : ROM address out, instruction in (same cycle)
//   ir_valid / ir_ready        : handshake to decode
//   ir_data / ir_pc            : held instruction and its line number
//   redirect_valid / _target   : jump request from execute
//   done / fault               : fetch stopped / bad jump target seen (sticky)
// Optional: FETCH_PERFCNT_EN adds perf_fetched and perf_stall counters.
module fetch_unit #(
   parameter int          PROG_LEN = 65,
   parameter logic [7:0]  RESET_PC = 8'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] rom_line,
   input  logic [7:0] rom_data,
   output logic       ir_valid,
   input  logic       ir_ready,
   output logic [7:0] ir_data,
   output logic [7:0] ir_pc,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_target,
   output logic       done,
`ifdef FETCH_PERFCNT_EN
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stall,
`endif
   output logic       fault
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [7:0] LAST = 8'(PROG_LEN - 1);

   state_t     r_state;
   logic [7:0] r_pc;
   logic [7:0] r_ir;
   logic [7:0] r_ir_pc;
   logic       r_valid;
   logic       r_done;
   logic       r_fault;

   logic w_redir;
   logic w_tgt_ok;
   logic w_load;
   logic w_start;

   // Redirect is ignored while idle and always beats load, stall and start.
   assign w_redir  = redirect_valid && (r_state != S_IDLE);
   assign w_tgt_ok = {1'b0, redirect_target} < 9'(PROG_LEN);
   assign w_load   = (r_state == S_RUN) && !w_redir
                     && (!r_valid || ir_ready);
   assign w_start  = start && (r_state != S_RUN) && !w_redir;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_ir    <= 8'd0;
         r_ir_pc <= 8'd0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
      end else if (w_redir) begin
         r_valid <= 1'b0;
         if (w_tgt_ok) begin
            r_pc    <= redirect_target;
            r_state <= S_RUN;
            r_done  <= 1'b0;
         end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_fault <= 1'b1;
         end
      end else begin
         unique case (r_state)
            S_RUN: begin
               if (w_load) begin
                  r_ir    <= rom_data;
                  r_ir_pc <= r_pc;
                  r_valid <= 1'b1;
                  // Last line: stop here, the PC never walks past the end.
                  if (r_pc == LAST) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_pc <= r_pc + 8'd1;
                  end
               end
            end
            S_IDLE, S_DONE: begin
               if (r_valid && ir_ready)
                  r_valid <= 1'b0;
               if (w_start) begin
                  r_state <= S_RUN;
                  r_pc    <= RESET_PC;
                  r_fault <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef FETCH_PERFCNT_EN
   logic [15:0] r_perf_fetched;
   logic [15:0] r_perf_stall;
   logic        w_stall;

   assign w_stall = r_valid && !ir_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_fetched <= 16'd0;
         r_perf_stall   <= 16'd0;
      end else if (w_start) begin
         r_perf_fetched <= 16'd0;
         r_perf_stall   <= 16'd0;
      end else begin
         if (w_load && (r_perf_fetched != 16'hFFFF))
            r_perf_fetched <= r_perf_fetched + 16'd1;
         if (w_stall && (r_perf_stall != 16'hFFFF))
            r_perf_stall <= r_perf_stall + 16'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_stall   = r_perf_stall;
`else
   // Performance counters are not built in this configuration.
`endif

   assign rom_line = r_pc;
   assign ir_valid = r_valid;
   assign ir_data  = r_ir;
   assign ir_pc    = r_ir_pc;
   assign done     = r_done;
   assign fault    = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a spec-level model
// checked every cycle plus literal expectations at key points.
module tb_fetch_unit;

   localparam int PL = 8;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] rom_line;
   logic [7:0] rom_data;
   logic       ir_valid;
   logic       ir_ready;
   logic [7:0] ir_data;
   logic [7:0] ir_pc;
   logic       redirect_valid;
   logic [7:0] redirect_target;
   logic       done;
   logic       fault;

   logic [7:0] rom [0:255];

   int tests = 0;
   int fails = 0;
   int acc7  = 0;

   fetch_unit #(.PROG_LEN(PL), .RESET_PC(8'd0)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .rom_line        (rom_line),
      .rom_data        (rom_data),
      .ir_valid        (ir_valid),
      .ir_ready        (ir_ready),
      .ir_data         (ir_data),
      .ir_pc           (ir_pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .done            (done),
      .fault           (fault)
   );

   assign rom_data = rom[rom_line];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Model: what a fetch stage must present, from the behavioural rules.
   bit         m_run;
   bit         m_stop;
   bit         m_fault;
   bit         m_v;
   logic [7:0] m_pc;
   logic [7:0] m_d;
   logic [7:0] m_ipc;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run <= 0; m_stop <= 0; m_fault <= 0; m_v <= 0;
         m_pc <= 8'd0; m_d <= 8'd0; m_ipc <= 8'd0;
      end else if (redirect_valid && (m_run || m_stop)) begin
         m_v <= 0;
         if (int'(redirect_target) < PL) begin
            m_pc <= redirect_target; m_run <= 1; m_stop <= 0;
         end else begin
            m_run <= 0; m_stop <= 1; m_fault <= 1;
         end
      end else if (m_run) begin
         if (!m_v || ir_ready) begin
            m_d <= rom[m_pc]; m_ipc <= m_pc; m_v <= 1;
            if (int'(m_pc) == PL - 1) begin
               m_run <= 0; m_stop <= 1;
            end else begin
               m_pc <= m_pc + 8'd1;
            end
         end
      end else begin
         if (m_v && ir_ready) m_v <= 0;
         if (start) begin
            m_run <= 1; m_stop <= 0; m_pc <= 8'd0; m_fault <= 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("rom_line", rom_line, m_pc);
      chk("rom_range", 32'(int'(rom_line) < PL), 1);
      chk("ir_valid", ir_valid, m_v);
      chk("ir_data", ir_data, m_d);
      chk("ir_pc", ir_pc, m_ipc);
      chk("done", done, m_stop);
      chk("fault", fault, m_fault);
      if (ir_valid && ir_ready && ir_pc == 8'd7) acc7++;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic ir(input string nm, input logic [7:0] d,
                     input logic [7:0] p);
      chk({nm, "_v"}, ir_valid, 1'b1);
      chk({nm, "_d"}, ir_data, d);
      chk({nm, "_pc"}, ir_pc, p);
   endtask

   initial begin
      rom[0] = 8'h8B; rom[1] = 8'h86; rom[2] = 8'h19; rom[3] = 8'h34;
      for (int i = 4; i < 256; i++) rom[i] = 8'(8'hA0 + i);
      rst = 0; start = 0; ir_ready = 0;
      redirect_valid = 0; redirect_target = 8'd0;
      step(); step();
      chk("rst_valid", ir_valid, 0);
      chk("rst_data", ir_data, 0);
      chk("rst_line", rom_line, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      rst = 1;
      step();
      start = 1; ir_ready = 1;                     // P0
      step(); start = 0;                           // P1
      chk("p1_valid", ir_valid, 0);
      step(); ir("l0", 8'h8B, 8'd0);               // P2
      step(); ir("l1", 8'h86, 8'd1);               // P3
      step(); ir("l2", 8'h19, 8'd2); ir_ready = 0; // P4
      for (int k = 0; k < 3; k++) begin            // P5..P7
         step();
         ir("stall", 8'h19, 8'd2);
         chk("stall_line", rom_line, 8'd3);
      end
      ir_ready = 1;
      step(); ir("l3", 8'h34, 8'd3);               // P8
      step(); ir("l4", 8'hA4, 8'd4);               // P9
      step(); ir("l5", 8'hA5, 8'd5);               // P10
      step(); ir("l6", 8'hA6, 8'd6);               // P11
      ir_ready = 0; redirect_valid = 1; redirect_target = 8'd4;
      step(); redirect_valid = 0;                  // P12
      chk("flush_valid", ir_valid, 0);
      step(); ir("redir4", 8'hA4, 8'd4);           // P13
      ir_ready = 1;
      step(); ir("r5", 8'hA5, 8'd5);               // P14
      step(); ir("r6", 8'hA6, 8'd6);               // P15
      step(); ir("l7", 8'hA7, 8'd7);               // P16
      chk("end_done", done, 1);
      chk("end_line", rom_line, 8'd7);
      ir_ready = 0;
      step(); ir("l7_hold", 8'hA7, 8'd7);          // P17
      chk("end_line2", rom_line, 8'd7);
      ir_ready = 1;
      step();                                      // P18
      chk("drain_valid", ir_valid, 0);
      chk("drain_done", done, 1);
      chk("l7_once", acc7, 1);
      start = 1;
      step(); start = 0;                           // P19
      chk("restart_done", done, 0);
      chk("restart_line", rom_line, 0);
      step(); ir("re_l0", 8'h8B, 8'd0);            // P20
      redirect_valid = 1; redirect_target = 8'd8;
      step(); redirect_valid = 0;                  // P21
      chk("bad8_fault", fault, 1);
      chk("bad8_done", done, 1);
      chk("bad8_valid", ir_valid, 0);
      chk("bad8_line", rom_line, 8'd1);
      step();                                      // P22
      redirect_valid = 1; redirect_target = 8'd7;
      step(); redirect_valid = 0;                  // P23
      chk("ok7_done", done, 0);
      chk("ok7_fault", fault, 1);
      step(); ir("ok7", 8'hA7, 8'd7);              // P24
      chk("ok7_end", done, 1);
      redirect_valid = 1; redirect_target = 8'd200;
      step();                                      // P25
      chk("bad200_fault", fault, 1);
      chk("bad200_valid", ir_valid, 0);
      start = 1; redirect_target = 8'd3;
      step(); start = 0; redirect_valid = 0;       // P26
      chk("win_fault", fault, 1);
      chk("win_line", rom_line, 8'd3);
      step(); ir("win_l3", 8'h34, 8'd3);           // P27
      start = 1;
      step(); start = 0;                           // P28
      ir("run_start", 8'hA4, 8'd4);
      redirect_valid = 1; redirect_target = 8'd9;
      step(); redirect_valid = 0;                  // P29
      chk("bad9_fault", fault, 1);
      start = 1;
      step(); start = 0;                           // P30
      chk("clr_fault", fault, 0);
      chk("clr_line", rom_line, 0);
      step(); ir("clr_l0", 8'h8B, 8'd0);           // P31
      ir_ready = 0;
      step(); ir("st_l0", 8'h8B, 8'd0);            // P32
      rst = 0;
      #1;
      chk("arst_valid", ir_valid, 0);
      chk("arst_data", ir_data, 0);
      chk("arst_pc", ir_pc, 0);
      chk("arst_line", rom_line, 0);
      chk("arst_done", done, 0);
      step(); rst = 1;
      redirect_valid = 1; redirect_target = 8'd2;
      step(); redirect_valid = 0;
      chk("idle_redir_line", rom_line, 0);
      chk("idle_redir_valid", ir_valid, 0);
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
